// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//   SRAM-side responder for the edge detector pixel path. Holds MEM_DEPTH
//   words of DW-bit RGB data, answers reads after READ_LATENCY cycles, commits
//   level-style writes, counts read/write accesses and flags protocol errors.
//
//   Optional feature macro: SRAM_RESP_INIT_EN
//     defined   : after rst the FSM sweeps zeros into the whole array, one word
//                 per cycle, with busy high; accesses are ignored meanwhile.
//     undefined : no INIT sweep, busy tied low, contents survive rst.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   address      : access address (W_ADDR_SIZE_BITS)
//   w_data       : write data (DW)
//   read_enable  : read strobe, level
//   write_enable : write strobe, level
//   r_data       : read data, holds between completions
//   r_valid      : one-cycle pulse when r_data updates
//   busy         : high while accesses are ignored (INIT sweep)
//   error        : sticky conflict / out-of-range flag
//   read_count   : launched reads, saturating
//   write_count  : write accesses, saturating
//
// READ_LATENCY must lie in 1..7.
// -----------------------------------------------------------------------------
module sram_responder #(
  parameter int W_ADDR_SIZE_BITS  = 16,
  parameter int W_DATA_SIZE_WORDS = 3,
  parameter int W_WORD_SIZE_BYTES = 1,
  parameter int MEM_DEPTH         = 256,
  parameter int READ_LATENCY      = 2,
  localparam int DW = W_DATA_SIZE_WORDS * W_WORD_SIZE_BYTES * 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [W_ADDR_SIZE_BITS-1:0] address,
  input  logic [DW-1:0]               w_data,
  input  logic                        read_enable,
  input  logic                        write_enable,
  output logic [DW-1:0]               r_data,
  output logic                        r_valid,
  output logic                        busy,
  output logic                        error,
  output logic [15:0]                 read_count,
  output logic [15:0]                 write_count
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_CONFLICT
  } state_e;

  state_e                      state_q, state_d, mode;
  logic [W_ADDR_SIZE_BITS-1:0] addr_q;
  logic                        error_q;
  logic [15:0]                 read_count_q, write_count_q;
`ifdef SRAM_RESP_INIT_EN
  logic [IDX_W-1:0]            init_addr_q;
`endif

  logic [DW-1:0]               mem [MEM_DEPTH];

  logic                        in_range;
  logic [IDX_W-1:0]            mem_idx;
  logic                        busy_c, access_evt, rd_launch, wr_evt, err_set;
  logic                        mem_wr;
  logic [IDX_W-1:0]            mem_waddr;
  logic [DW-1:0]               mem_wdata;

  logic [DW-1:0]               pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0]     pipe_vld_q;
  logic [DW-1:0]               r_data_q;
  logic                        r_valid_q;

  assign in_range = ({1'b0, address} < (W_ADDR_SIZE_BITS+1)'(MEM_DEPTH));
  assign mem_idx  = address[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic: the mode follows the enables sampled this cycle.
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mode = ST_IDLE;
    unique case ({read_enable, write_enable})
      2'b10:   mode = ST_READ;
      2'b01:   mode = ST_WRITE;
      2'b11:   mode = ST_CONFLICT;
      default: mode = ST_IDLE;
    endcase
    state_d = mode;
`ifdef SRAM_RESP_INIT_EN
    if (state_q == ST_INIT) begin
      state_d = (init_addr_q == IDX_W'(MEM_DEPTH - 1)) ? ST_IDLE : ST_INIT;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output / action decode.
  // An access event is a cycle with an enable high where either the mode or the
  // address changed; holding a strobe on a stable address is one access.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_c     = 1'b0;
    rd_launch  = 1'b0;
    wr_evt     = 1'b0;
    err_set    = 1'b0;
    mem_wr     = 1'b0;
    mem_waddr  = mem_idx;
    mem_wdata  = w_data;
    access_evt = (read_enable || write_enable) &&
                 ((state_q != state_d) || (address != addr_q));
`ifdef SRAM_RESP_INIT_EN
    busy_c = (state_q == ST_INIT);
    if (busy_c) begin
      mem_wr    = 1'b1;
      mem_waddr = init_addr_q;
      mem_wdata = '0;
    end
`endif
    if (!busy_c) begin
      // Writes are level-sensitive: every WRITE cycle in range updates memory.
      mem_wr    = (state_d == ST_WRITE) && in_range;
      rd_launch = access_evt && (state_d == ST_READ);
      wr_evt    = access_evt && (state_d == ST_WRITE);
      err_set   = ((state_d == ST_CONFLICT) && (state_q != ST_CONFLICT)) ||
                  ((state_d == ST_WRITE) && !in_range) ||
                  (rd_launch && !in_range);
    end
  end

  // ---------------------------------------------------------------------------
  // State register, address history, counters, sticky error.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking '<=' so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SRAM_RESP_INIT_EN
      state_q     <= ST_INIT;
      init_addr_q <= '0;
`else
      state_q     <= ST_IDLE;
`endif
      addr_q        <= '0;
      error_q       <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      state_q <= state_d;
`ifdef SRAM_RESP_INIT_EN
      if (state_q == ST_INIT) init_addr_q <= init_addr_q + 1'b1;
`endif
      if (!busy_c) addr_q <= address;
      if (err_set) error_q <= 1'b1;
      if (rd_launch && (read_count_q != 16'hFFFF)) read_count_q <= read_count_q + 16'd1;
      if (wr_evt && (write_count_q != 16'hFFFF)) write_count_q <= write_count_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array. rst only blocks a same-cycle write (reset wins).
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; it maps onto RAM and its contents are
  // only cleared by the optional INIT sweep.
  always_ff @(posedge clk) begin
    if (mem_wr && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: data captured at the launch edge (later writes cannot alter
  // it), then READ_LATENCY-1 shifts and the output register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      pipe_vld_q[0] <= rd_launch;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      r_valid_q <= pipe_vld_q[READ_LATENCY-1];
      if (pipe_vld_q[READ_LATENCY-1]) r_data_q <= pipe_data_q[READ_LATENCY-1];
    end
  end

  // Payload needs no reset: it is only observed alongside a valid bit.
  always_ff @(posedge clk) begin
    if (rd_launch) pipe_data_q[0] <= in_range ? mem[mem_idx] : '0;
    for (int i = 1; i < READ_LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

  assign r_data      = r_data_q;
  assign r_valid     = r_valid_q;
  assign busy        = busy_c;
  assign error       = error_q;
  assign read_count  = read_count_q;
  assign write_count = write_count_q;

endmodule

// File: doc/sram_responder.md
# sram_responder

Behavioural and synthesizable SRAM-side responder for the edge detector's pixel path. It is the target end of the SRAM control interface driven by the pixel controller: `address`, `w_data`, `read_enable`, `write_enable` in, `r_data` out. It holds a parameterized on-chip array of 24-bit RGB words, returns read data after a fixed pipeline latency, commits writes, counts accesses and flags protocol errors. It replaces the off-chip SRAM in block-level and full-chip simulation, and serves as a small on-chip frame buffer.

## Interface
Parameters:
- `W_ADDR_SIZE_BITS`, 16: address width.
- `W_DATA_SIZE_WORDS`, 3: words per access.
- `W_WORD_SIZE_BYTES`, 1: bytes per word. Data width is DW = W_DATA_SIZE_WORDS*W_WORD_SIZE_BYTES*8 (24).
- `MEM_DEPTH`, 256: number of implemented words at addresses 0..MEM_DEPTH-1.
- `READ_LATENCY`, 2: cycles from read launch to data. Legal range is 1..7.

Ports:
- `clk` input 1: the single clock. Everything is on its rising edge.
- `rst` input 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `address` input W_ADDR_SIZE_BITS: access address.
- `w_data` input DW: write data.
- `read_enable` input 1: read strobe, level.
- `write_enable` input 1: write strobe, level.
- `r_data` output DW: read data. Holds its value between completions.
- `r_valid` output 1: one-cycle pulse when `r_data` updates.
- `busy` output 1: accesses are ignored while high.
- `error` output 1: sticky protocol/range error.
- `read_count` output 16: launched reads, saturating.
- `write_count` output 16: write accesses, saturating.

## Operation
- FSM states: INIT, IDLE, READ, WRITE, CONFLICT. The state is registered from the enables sampled each edge.
  - Next state is READ when only `read_enable` is high.
  - Next state is WRITE when only `write_enable` is high.
  - Next state is CONFLICT when both enables are high.
  - Next state is IDLE when neither is high.
  - INIT applies only with the Configuration macro.
- Access event: a cycle with an enable high and either:
  - the previous state differs from the new mode, or
  - `address` differs from the previous cycle's registered address.
  - Holding an enable with a stable address is therefore one access. This matches the controller's multi-cycle hold per pixel.
- Write:
  - Every cycle in WRITE mode with `address` < MEM_DEPTH, `mem[address] <= w_data`. Level behaviour, so the last value before the address changes wins.
  - `write_count` increments once per write access event.
- Read:
  - On each read access event, launch a read of `mem[address]` into a READ_LATENCY-deep pipeline.
  - Data is captured at the launch edge; later writes do not alter an in-flight read.
  - One launch per cycle maximum. `read_count` increments on launch.
- Out of range (`address` >= MEM_DEPTH):
  - A write is dropped and sets `error`.
  - A read still launches, returns 0 with `r_valid`, and sets `error`.
  - Both still count.
- CONFLICT: no memory access, no launch, no count. Sets `error` on entry.
- Counters saturate at 16'hFFFF. `error` clears only on `rst`.

## Timing
- Reset values:
  - `r_data` = 0, `r_valid` = 0, `busy` = 0, `error` = 0.
  - Both counters = 0.
  - State = IDLE.
  - Previous-address register = 0.
  - Read pipeline is flushed.
- Reset mid-read: in-flight reads are discarded and no `r_valid` follows.
- Memory contents are not altered by `rst`, except when the Configuration macro is defined.
- Read latency:
  - A read launched at edge k updates `r_data` and pulses `r_valid` for one cycle at edge k+READ_LATENCY.
  - Back-to-back launches produce back-to-back pulses.
- Write latency: `w_data` sampled at edge k is readable by a read launched at edge k+1.
- Read then write to the same address on consecutive cycles: the read returns the old data.
- `rst` asserted together with enables: reset wins, and no access or count occurs.

## Configuration
- Macro: `SRAM_RESP_INIT_EN`.
- Defined:
  - After `rst` deasserts, the FSM enters INIT and writes 0 to addresses 0..MEM_DEPTH-1, one per cycle.
  - `busy` = 1 for exactly MEM_DEPTH cycles. During this time enables are ignored and not counted.
  - The FSM then goes to IDLE and `busy` falls.
  - `rst` during INIT restarts the sweep at address 0.
- Not defined:
  - No INIT state. `busy` is tied to 0.
  - Memory contents are undefined at power-up and preserved across `rst`.

## Test plan
- Write then read: write 24'hA1B2C3 to address 5 for 10 cycles, idle 1 cycle, then read address 5 with READ_LATENCY=2.
  - Response: `r_valid` pulses 2 cycles after launch with `r_data` = 24'hA1B2C3.
  - `write_count` = 1, `read_count` = 1.
- Held read with stepping address: hold `read_enable` high while stepping address 0..3 every 10 cycles.
  - Response: exactly 4 launches and 4 `r_valid` pulses, each 2 cycles after its address change.
  - `read_count` = 4.
- Both enables high for 3 cycles.
  - Response: `error` = 1 from the next edge and remains 1.
  - No memory change; counters unchanged.
- Out-of-range access: address = MEM_DEPTH.
  - Read returns `r_data` = 0 with `r_valid` and sets `error`.
  - Write leaves mem[0..MEM_DEPTH-1] unchanged.
- Reset mid-operation: assert `rst` one cycle after a read launch.
  - Response: no `r_valid` ever follows.
  - Outputs and counters are 0 on the next edge; previously written data is still readable (macro undefined).
- With `SRAM_RESP_INIT_EN` defined:
  - After reset, `busy` is high for exactly MEM_DEPTH cycles.
  - A read of address 7 afterwards returns 0.
  - A write issued while `busy` is high does not increment `write_count`.
